lfsr_px_source: RTL



---
 rtl/lfsr_px_source.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lfsr_px_source.sv
// lfsr_px_source: SPI pixel pass-through or Galois-LFSR test-pattern source; LFSR_PX_COUNT_EN adds px_count_o.
// Latency: one cycle from spi_px_rdy_i or an LFSR step to the px_rdy_o pulse.
// No backpressure: px_rdy_o is a one-cycle pulse; run_i low pauses generation in place.
module lfsr_px_source #(
  parameter int                    PX_WIDTH   = 24,
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
  parameter int                    PX_GAP     = 0
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic                cfg_valid_i,
  input  logic [7:0]          cfg_byte_i,
  output logic                cfg_done_o,
  input  logic                select_input_i,
  input  logic [PX_WIDTH-1:0] spi_px_i,
  input  logic                spi_px_rdy_i,
  input  logic                run_i,
  output logic [PX_WIDTH-1:0] px_o,
  output logic                px_rdy_o,
  output logic                lfsr_done_o
`ifdef LFSR_PX_COUNT_EN
  ,
  output logic [15:0]         px_count_o
`endif
);
  localparam int NB = LFSR_WIDTH / 8;
  localparam int CW = $clog2(2 * NB + 1);
  localparam int GW = (PX_GAP > 0) ? $clog2(PX_GAP + 1) : 1;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]         byte_cnt_q, byte_idx;
  logic [LFSR_WIDTH-1:0] seed_q, stop_q, lfsr_q, lfsr_nxt, seed_guard;
  logic [LFSR_WIDTH-1:0] shift_seed, shift_stop;
  logic [GW-1:0]         gap_q;
  logic [PX_WIDTH-1:0]   gen_px;
  logic                  restart, accept, load_last, step, hit, run_entry;

  always_comb begin
    restart    = cfg_valid_i && (state_q == S_READY || state_q == S_DONE);
    accept     = cfg_valid_i && (state_q == S_LOAD || restart);
    byte_idx   = restart ? '0 : byte_cnt_q;
    load_last  = accept && (byte_idx == CW'(2 * NB - 1));
    shift_seed = LFSR_WIDTH'({seed_q, cfg_byte_i});
    shift_stop = LFSR_WIDTH'({stop_q, cfg_byte_i});
    // An all-zero seed would lock the LFSR up, so it is promoted to 1.
    seed_guard = (seed_q == '0) ? LFSR_WIDTH'(1) : seed_q;
    run_entry  = (state_q == S_READY) && !cfg_valid_i && run_i;
    step       = (state_q == S_RUN) && run_i && select_input_i && (gap_q == '0);
    lfsr_nxt   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    hit        = (lfsr_nxt == stop_q) || (lfsr_nxt == seed_q);
  end

  for (genvar g = 0; g < PX_WIDTH; g++) begin : g_rep
    assign gen_px[g] = lfsr_nxt[g % LFSR_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_last) state_d = S_READY;
      S_READY: if (cfg_valid_i) state_d = S_LOAD;
               else if (run_i) state_d = S_RUN;
      S_RUN:   if (step && hit) state_d = S_DONE;
      S_DONE:  if (cfg_valid_i) state_d = S_LOAD;
               else if (!run_i) state_d = S_READY;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= S_LOAD;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      byte_cnt_q  <= '0;
      seed_q      <= '0;
      stop_q      <= '0;
      lfsr_q      <= '0;
      gap_q       <= '0;
      cfg_done_o  <= 1'b0;
      lfsr_done_o <= 1'b0;
      px_o        <= '0;
      px_rdy_o    <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt_q <= load_last ? '0 : byte_idx + 1'b1;
        if (byte_idx < CW'(NB)) seed_q <= shift_seed;
        else                    stop_q <= shift_stop;
      end
      if (load_last) begin
        seed_q     <= seed_guard;
        lfsr_q     <= seed_guard;
        cfg_done_o <= 1'b1;
      end
      if (restart) begin
        cfg_done_o  <= 1'b0;
        lfsr_done_o <= 1'b0;
      end
      if (step) begin
        lfsr_q <= lfsr_nxt;
        gap_q  <= GW'(PX_GAP);
        if (hit) lfsr_done_o <= 1'b1;
      end else if (state_q == S_RUN && run_i && gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
      if (run_entry) gap_q <= '0;
      if (state_q == S_DONE && !cfg_valid_i && !run_i) begin
        lfsr_q      <= seed_q;
        lfsr_done_o <= 1'b0;
      end
      // SPI path owns the output whenever it is selected, regardless of state.
      if (!select_input_i) begin
        px_o     <= spi_px_i;
        px_rdy_o <= spi_px_rdy_i;
      end else if (step) begin
        px_o     <= gen_px;
        px_rdy_o <= 1'b1;
      end else begin
        px_rdy_o <= 1'b0;
      end
    end
  end

`ifdef LFSR_PX_COUNT_EN
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                             px_count_o <= '0;
    else if (run_entry)                        px_count_o <= '0;
    else if (step && px_count_o != 16'hFFFF)   px_count_o <= px_count_o + 1'b1;
  end
`endif

endmodule
